// File: rtl/seq_gen_sched_if.sv
// rtl/seq_gen_sched_if.sv - client-side request/result bus of the sequence generator scheduler
interface seq_gen_sched_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int ID_W   = 2
);
    logic [NREQ-1:0]        req;
    logic [NREQ*LEN_W-1:0]  len_in;
    logic [NREQ*DATA_W-1:0] pat_in;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [DATA_W-1:0]      result;

    // Requester side
    modport master (
        output req, len_in, pat_in,
        input  grant, busy, done, done_id, result
    );

    // Scheduler side
    modport slave (
        input  req, len_in, pat_in,
        output grant, busy, done, done_id, result
    );
endinterface

// File: rtl/seq_gen_sched.sv
// rtl/seq_gen_sched.sv - round-robin scheduler sharing one serial sequence generator
module seq_gen_sched #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int ID_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    seq_gen_sched_if.slave    bus,
    output logic              o_gen_rst,
    output logic              o_gen_xin,
    input  logic              i_gen_yout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_k;
    logic [DATA_W-1:0] r_pat;
    logic [DATA_W-1:0] r_cap;
    logic [DATA_W-1:0] r_result;
    logic [ID_W-1:0]   r_done_id;

    logic              w_found;
    logic [ID_W-1:0]   w_pick;
    int                w_idx;
    logic [NREQ-1:0]   w_req_sh;
    logic [LEN_W-1:0]  w_len_raw;
    logic [LEN_W-1:0]  w_len_clamp;
    logic [DATA_W-1:0] w_pat_sel;
    logic [DATA_W-1:0] w_pat_sh;
    logic              w_last_run;
    logic [DATA_W-1:0] w_cap_final;
    logic [ID_W-1:0]   w_ptr_next;
    logic [NREQ-1:0]   w_grant;
    logic              w_busy;
    logic              w_done;
    logic              w_xin;
    logic              w_clr;

    // Cyclic search for the first requesting client at or after the RR pointer
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_idx    = 0;
        w_req_sh = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_idx    = (int'(r_ptr) + off) % NREQ;
            w_req_sh = bus.req >> w_idx;
            if (!w_found && w_req_sh[0]) begin
                w_found = 1'b1;
                w_pick  = ID_W'(w_idx);
            end
        end
    end

    // Select the winner's length/pattern slices; oversize lengths clamp to DATA_W
    always_comb begin
        w_len_raw   = LEN_W'(bus.len_in >> (int'(w_pick) * LEN_W));
        w_pat_sel   = DATA_W'(bus.pat_in >> (int'(w_pick) * DATA_W));
        w_len_clamp = (w_len_raw > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : w_len_raw;
    end

    // Bit-serial helpers: current Xin bit, last RUN cycle, final captured word
    always_comb begin
        w_pat_sh    = r_pat >> r_k;
        w_last_run  = (r_k == (r_len - LEN_W'(1)));
        w_cap_final = r_cap | (DATA_W'(i_gen_yout) << (r_len - LEN_W'(1)));
        w_ptr_next  = (r_id == ID_W'(NREQ - 1)) ? '0 : (r_id + ID_W'(1));
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_found ? S_CLR : S_IDLE;
            S_CLR:   w_next = (r_len == '0) ? S_DONE : S_RUN;
            S_RUN:   w_next = w_last_run ? S_DRAIN : S_RUN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        w_grant = '0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_xin   = 1'b0;
        w_clr   = 1'b0;
        if (r_state != S_IDLE) begin
            w_grant = NREQ'(1) << r_id;
            w_busy  = 1'b1;
        end
        case (r_state)
            S_CLR:   w_clr  = 1'b1;
            S_RUN:   w_xin  = w_pat_sh[0];
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Burst datapath: latch request, count bits, capture Yout, publish result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_k       <= '0;
            r_pat     <= '0;
            r_cap     <= '0;
            r_result  <= '0;
            r_done_id <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id  <= w_pick;
                        r_len <= w_len_clamp;
                        r_pat <= w_pat_sel;
                    end
                end
                S_CLR: begin
                    r_k   <= '0;
                    r_cap <= '0;
                    if (r_len == '0) begin
                        r_result  <= '0;
                        r_done_id <= r_id;
                    end
                end
                S_RUN: begin
                    r_k <= r_k + LEN_W'(1);
                    // Yout lags Xin by one clock, so bit k-1 is visible at step k
                    if (r_k != '0) begin
                        r_cap <= r_cap | (DATA_W'(i_gen_yout) << (r_k - LEN_W'(1)));
                    end
                end
                S_DRAIN: begin
                    r_cap     <= w_cap_final;
                    r_result  <= w_cap_final;
                    r_done_id <= r_id;
                end
                S_DONE: begin
                    r_ptr <= w_ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant   = w_grant;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.done_id = r_done_id;
    assign bus.result  = r_result;
    assign o_gen_rst   = reset | w_clr;
    assign o_gen_xin   = w_xin;

endmodule

// File: tb/tb_seq_gen_sched.sv
// tb/tb_seq_gen_sched.sv - directed-vector bench for seq_gen_sched with a 3-bit generator model
module tb_seq_gen_sched;

    localparam int NREQ   = 4;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;
    localparam int ID_W   = 2;

    logic clk;
    logic reset;
    logic gen_rst;
    logic gen_xin;
    logic gen_yout;
    logic [2:0] g;

    int n_vec;
    int n_bad;
    logic [2:0] gtrace [0:63];

    seq_gen_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    seq_gen_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_gen_rst  (gen_rst),
        .o_gen_xin  (gen_xin),
        .i_gen_yout (gen_yout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 3-bit sequence generator: Xin=1 starts a count 1..5 that wraps to 0
    always_ff @(posedge clk) begin
        if (gen_rst) g <= 3'd0;
        else if (g == 3'd0) g <= {2'b00, gen_xin};
        else if (g == 3'd5) g <= 3'd0;
        else g <= g + 3'd1;
    end
    assign gen_yout = (g == 3'd3) || (g == 3'd5);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int id, input int len, input logic [15:0] pat,
                         input logic [15:0] exp_res, input string name);
        int cyc, gcnt, rcnt, rfirst, dcyc, dcnt, ohbad, exp_occ;
        logic [3:0] gmask;
        exp_occ = (len == 0) ? 2 : (((len > 16) ? 16 : len) + 3);
        gmask = 4'b0001 << id;
        cyc = 0; gcnt = 0; rcnt = 0; rfirst = -1; dcyc = -1; dcnt = 0; ohbad = 0;
        bus.len_in[id*LEN_W +: LEN_W]   = len[4:0];
        bus.pat_in[id*DATA_W +: DATA_W] = pat;
        bus.req[id] = 1'b1;
        while (dcnt == 0 && cyc < 60) begin
            step();
            cyc++;
            if (cyc < 64) gtrace[cyc] = g;
            if (bus.grant == gmask) gcnt++;
            else if (bus.grant != 4'b0000) ohbad++;
            if (gen_rst) begin
                rcnt++;
                if (rfirst < 0) rfirst = cyc;
            end
            if (cyc == 1) begin
                bus.req[id] = 1'b0;
                bus.len_in[id*LEN_W +: LEN_W]   = 5'd3;
                bus.pat_in[id*DATA_W +: DATA_W] = 16'hFFFF;
            end
            if (bus.done) begin
                dcnt++;
                dcyc = cyc;
                chk({name, "_done_id"}, 32'(bus.done_id), 32'(id));
                chk({name, "_result"}, 32'(bus.result), 32'(exp_res));
            end
        end
        chk({name, "_done_seen"}, 32'(dcnt), 32'd1);
        chk({name, "_done_lat"}, 32'(dcyc), 32'(exp_occ));
        chk({name, "_grant_cycles"}, 32'(gcnt), 32'(exp_occ));
        chk({name, "_gen_rst_cycles"}, 32'(rcnt), 32'd1);
        chk({name, "_gen_rst_pos"}, 32'(rfirst), 32'd1);
        chk({name, "_grant_onehot"}, 32'(ohbad), 32'd0);
        step();
        chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({name, "_idle"}, 32'(bus.busy), 32'd0);
        chk({name, "_result_hold"}, 32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ohbad, bound, didx, rdone;
        int order [0:4];
        int exp_ord [0:4];
        logic [3:0] prevg;
        exp_ord = '{0, 1, 2, 3, 0};
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.req = '0;
        bus.len_in = '0;
        bus.pat_in = '0;
        step();
        step();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_done_id", 32'(bus.done_id), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_gen_rst", 32'(gen_rst), 32'd1);
        chk("rst_gen_xin", 32'(gen_xin), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_gen_rst", 32'(gen_rst), 32'd0);

        // All four requesting with len=2: fair rotation 0,1,2,3,0
        bus.len_in = {4{5'd2}};
        bus.req = 4'hF;
        prevg = '0; n = 0; ohbad = 0; bound = 0;
        while (!(n == 5 && !bus.busy) && bound < 100) begin
            step();
            bound++;
            if (bus.grant != 4'b0000 && !$onehot(bus.grant)) ohbad++;
            if (bus.grant != 4'b0000 && bus.grant != prevg && n < 5) begin
                for (int i = 0; i < NREQ; i++) if (bus.grant[i]) order[n] = i;
                n++;
                if (n == 5) bus.req = '0;
            end
            prevg = bus.grant;
        end
        chk("rr_grants", 32'(n), 32'd5);
        chk("rr_onehot", 32'(ohbad), 32'd0);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_ord[i]));

        // Case 1: generator walk 1..5,0 and Yout word 0x0014
        burst(0, 6, 16'h0001, 16'h0014, "c1");
        for (int i = 0; i < 6; i++) chk($sformatf("c1_gen_state%0d", i), 32'(gtrace[3+i]), 32'((i + 1) % 6));

        // Case 2: all-zero pattern
        burst(1, 8, 16'h0000, 16'h0000, "c2");

        // Case 5: oversize length clamps to 16
        burst(3, 31, 16'h0001, 16'h0014, "c5");

        // Case 4: zero length skips RUN
        burst(2, 0, 16'hABCD, 16'h0000, "c4");

        // Case 6: reset during RUN, then re-serve the still-pending request
        bus.len_in[0 +: LEN_W]  = 5'd6;
        bus.pat_in[0 +: DATA_W] = 16'h0001;
        bus.req[0] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("c6_pre_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("c6_rst_grant", 32'(bus.grant), 32'd0);
        chk("c6_rst_busy", 32'(bus.busy), 32'd0);
        chk("c6_rst_gen_rst", 32'(gen_rst), 32'd1);
        chk("c6_rst_result", 32'(bus.result), 32'd0);
        rdone = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.done) rdone++;
        end
        chk("c6_rst_no_done", 32'(rdone), 32'd0);
        reset = 1'b0;
        burst(0, 6, 16'h0001, 16'h0014, "c6");
        didx = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
